// File: rtl/filter_mem_bank.sv
// Multi-bank filter-weight store: NoC writes fill per-bank load bitmaps;
// rd_start streams one full DEPTH_F x DEPTH_F filter row-major to the PEs.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   wr_valid/wr_ready               write handshake
//   wr_addr, wr_data                {bank, index} address and weight
//   clr                             clear all load bitmaps (data kept)
//   rd_start, rd_bank               request a stream of one bank
//   out_valid/out_ready             stream handshake
//   out_data, out_idx, out_last     streamed weight, its index, final beat
//   bank_loaded                     per-bank "all entries written" flags
//   addr_err, rd_err                one-cycle error pulses
module filter_mem_bank #(
  parameter int WIDTH_DATA = 8,
  parameter int WIDTH_ADDR = 12,
  parameter int DEPTH_F    = 5,
  parameter int NUM_BANKS  = 4,
  localparam int N      = DEPTH_F * DEPTH_F,
  localparam int IDX_W  = $clog2(N),
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WIDTH_ADDR-1:0] wr_addr,
  input  logic [WIDTH_DATA-1:0] wr_data,
  input  logic                  clr,
  input  logic                  rd_start,
  input  logic [BANK_W-1:0]     rd_bank,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH_DATA-1:0] out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last,
  output logic [NUM_BANKS-1:0]  bank_loaded,
  output logic                  addr_err,
  output logic                  rd_err
);

  localparam int BF_W = WIDTH_ADDR - IDX_W;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic              rd_err_d;

  logic [WIDTH_DATA-1:0] mem [NUM_BANKS][N];
  logic [NUM_BANKS-1:0][N-1:0] bitmap;

  logic [IDX_W-1:0]  wr_idx;
  logic [BF_W-1:0]   wr_bf;
  logic [BANK_W-1:0] wr_bsel;
  logic              wr_ok;
  logic              wr_fire;
  logic              rd_ok;

  assign wr_idx  = wr_addr[IDX_W-1:0];
  assign wr_bf   = wr_addr[WIDTH_ADDR-1:IDX_W];
  assign wr_bsel = wr_bf[BANK_W-1:0];

  // Full-width bank compare: nonzero upper bits make the address invalid.
  assign wr_ok = ({1'b0, wr_idx} < (IDX_W+1)'(N)) &&
                 (wr_bf < BF_W'(NUM_BANKS));

  // The bank being streamed is frozen so the stream sees stable data.
  assign wr_ready = rst_n &&
                    !(state_q == STREAM && wr_bf == BF_W'(bank_q));

  assign wr_fire = wr_valid && wr_ready;

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_loaded[b] = &bitmap[b];
    end
  end

  assign rd_ok = ({1'b0, rd_bank} < (BANK_W+1)'(NUM_BANKS)) &&
                 bank_loaded[rd_bank];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int i = 0; i < N; i++) begin
          mem[b][i] <= '0;
        end
      end
      bitmap   <= '0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= wr_fire && !wr_ok;
      if (clr) begin
        bitmap <= '0;
      end
      // Placed after clr so a coincident write keeps its bit.
      if (wr_fire && wr_ok) begin
        mem[wr_bsel][wr_idx]    <= wr_data;
        bitmap[wr_bsel][wr_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bank_q  <= '0;
      rd_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bank_q  <= bank_d;
      rd_err  <= rd_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    bank_d   = bank_q;
    rd_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_start) begin
          if (rd_ok) begin
            state_d = STREAM;
            bank_d  = rd_bank;
            idx_d   = '0;
          end else begin
            rd_err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (idx_q == IDX_W'(N-1)) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == STREAM);
  assign out_data  = mem[bank_q][idx_q];
  assign out_idx   = idx_q;
  assign out_last  = out_valid && (idx_q == IDX_W'(N-1));

endmodule
